tinuc_pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage TinuC core. Drives enable/clear of PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB banks. Handles load-use stalls, branch flushes (resolved in MEM),

---
 rtl/tinuc_pipe_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_tinuc_pipe_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinuc_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage TinuC core: bank enables/clears, load-use stalls,
// branch flushes, data-RAM wait states, halt-with-drain and saturating perf counters.
module tinuc_pipe_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_tk,
    input  logic             mem_access,
    input  logic             mem_ack,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic             memwb_clr,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned WcntW = $clog2(TIMEOUT + 1);
    localparam int unsigned DcntW = $clog2(DRAIN_CYC + 1);
    localparam logic [WcntW-1:0] WcntLast = WcntW'(TIMEOUT - 1);
    localparam logic [DcntW-1:0] DcntLast = DcntW'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [WcntW-1:0]   wcnt_q, wcnt_d;
    logic [DcntW-1:0]   dcnt_q, dcnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic lu_haz;
    logic freeze;
    logic flush;
    logic stall;

    assign lu_haz = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StRun;
            ret_q       <= StRun;
            wcnt_q      <= '0;
            dcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wcnt_q      <= wcnt_d;
            dcnt_q      <= dcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        wcnt_d      = wcnt_q;
        dcnt_d      = dcnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        if (stall && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (freeze && (wait_cnt_q != CntMax)) wait_cnt_d = wait_cnt_q + CNT_W'(1);

        unique case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d = StMemWait;
                    ret_d   = StRun;
                    wcnt_d  = WcntW'(1);
                end else if (!flush && !stall && halt_req) begin
                    state_d = StDrain;
                    dcnt_d  = '0;
                end
            end
            StMemWait: begin
                if (mem_ack) begin
                    state_d = ret_q;
                    wcnt_d  = '0;
                end else if (wcnt_q == WcntLast) begin
                    mem_err_d = 1'b1;
                    state_d   = StHalted;
                    wcnt_d    = '0;
                end else begin
                    wcnt_d = wcnt_q + WcntW'(1);
                end
            end
            StDrain: begin
                // A RAM wait pauses the drain count; it resumes on return from MemWait.
                if (freeze) begin
                    state_d = StMemWait;
                    ret_d   = StDrain;
                    wcnt_d  = WcntW'(1);
                end else if (dcnt_q == DcntLast) begin
                    state_d = StHalted;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DcntW'(1);
                end
            end
            StHalted: begin
                if (!halt_req && !mem_err_q) state_d = StRun;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        memwb_clr = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_access && !mem_ack) freeze = 1'b1;
                else if (mem_branch_tk)     flush  = 1'b1;
                else if (lu_haz)            stall  = 1'b1;
            end
            StMemWait: begin
                if (!mem_ack)           freeze = 1'b1;
                else if (mem_branch_tk) flush  = 1'b1;
                else if (lu_haz)        stall  = 1'b1;
            end
            StDrain: begin
                if (mem_access && !mem_ack) begin
                    freeze = 1'b1;
                end else begin
                    pc_en    = 1'b0;
                    ifid_clr = 1'b1;
                    flush    = mem_branch_tk;
                end
            end
            StHalted: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
        endcase

        if (freeze) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            memwb_clr = 1'b1;
        end
        if (flush) begin
            pc_en     = 1'b1;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
        end
        if (stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end
    end

    assign halted    = (state_q == StHalted);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_tinuc_pipe_ctrl.sv
// Directed bench for tinuc_pipe_ctrl: stalls, flushes, RAM waits, timeout, drain, saturation.
module tb_tinuc_pipe_ctrl;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned TIMEOUT   = 4;
    localparam int unsigned DRAIN_CYC = 4;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_memread;
    logic             mem_branch_tk, mem_access, mem_ack, halt_req;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic             halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic [4:0]       en_v;
    logic [3:0]       clr_v;

    int n_checks = 0;
    int n_fail   = 0;

    assign en_v  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign clr_v = {ifid_clr, idex_clr, exmem_clr, memwb_clr};

    always #5 CLK = ~CLK;

    tinuc_pipe_ctrl #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .mem_branch_tk(mem_branch_tk),
        .mem_access   (mem_access),
        .mem_ack      (mem_ack),
        .halt_req     (halt_req),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_clr     (ifid_clr),
        .idex_clr     (idex_clr),
        .exmem_clr    (exmem_clr),
        .memwb_clr    (memwb_clr),
        .halted       (halted),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .wait_cnt     (wait_cnt)
    );

    task automatic idle();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; mem_branch_tk = 1'b0;
        mem_access = 1'b0; mem_ack = 1'b0; halt_req = 1'b0;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        RESET_N = 1'b0;
        idle();
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        idle();
        @(negedge CLK); #1;
        n_checks++; if (en_v !== 5'b11111) begin n_fail++; $display("FAIL reset_en got %b exp 11111", en_v); end
        n_checks++; if (clr_v !== 4'b0000) begin n_fail++; $display("FAIL reset_clr got %b exp 0000", clr_v); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err got %b exp 0", mem_err); end
        n_checks++; if ({stall_cnt, flush_cnt, wait_cnt} !== 12'd0) begin
            n_fail++; $display("FAIL reset_cnts got %0d/%0d/%0d exp 0/0/0", stall_cnt, flush_cnt, wait_cnt);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        // lw x5 in EX, add x6,x5,x1 in ID
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        #1;
        n_checks++; if (en_v !== 5'b00111) begin n_fail++; $display("FAIL lu_en got %b exp 00111", en_v); end
        n_checks++; if (clr_v !== 4'b0100) begin n_fail++; $display("FAIL lu_clr got %b exp 0100", clr_v); end
        @(negedge CLK); idle(); #1;
        n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        n_checks++; if (en_v !== 5'b11111) begin n_fail++; $display("FAIL lu_after_en got %b exp 11111", en_v); end
    endtask

    task automatic test_no_stall();
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        n_checks++; if ({en_v, clr_v} !== 9'b11111_0000) begin
            n_fail++; $display("FAIL nostall_x0 got %b/%b exp 11111/0000", en_v, clr_v);
        end
        @(negedge CLK);
        ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        n_checks++; if ({en_v, clr_v} !== 9'b11111_0000) begin
            n_fail++; $display("FAIL nostall_rs2 got %b/%b exp 11111/0000", en_v, clr_v);
        end
        @(negedge CLK); idle(); #1;
        n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL nostall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; mem_branch_tk = 1'b1;
        #1;
        n_checks++; if (en_v !== 5'b11111) begin n_fail++; $display("FAIL br_en got %b exp 11111", en_v); end
        n_checks++; if (clr_v !== 4'b1110) begin n_fail++; $display("FAIL br_clr got %b exp 1110", clr_v); end
        @(negedge CLK); idle(); #1;
        n_checks++; if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
            n_fail++; $display("FAIL br_cnts got flush %0d stall %0d exp 1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_access = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({en_v, clr_v} !== 9'b00000_0001) begin
                n_fail++; $display("FAIL wait_freeze%0d got %b/%b exp 00000/0001", i, en_v, clr_v);
            end
            @(negedge CLK);
        end
        mem_ack = 1'b1;
        #1;
        n_checks++; if ({en_v, clr_v} !== 9'b11111_0000) begin
            n_fail++; $display("FAIL wait_ack got %b/%b exp 11111/0000", en_v, clr_v);
        end
        n_checks++; if (wait_cnt !== 4'd3) begin n_fail++; $display("FAIL wait_cnt got %0d exp 3", wait_cnt); end
        @(negedge CLK); idle(); #1;
        n_checks++; if ({en_v, halted, wait_cnt} !== {5'b11111, 1'b0, 4'd3}) begin
            n_fail++; $display("FAIL wait_resume got en %b halted %b cnt %0d exp 11111/0/3", en_v, halted, wait_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_access = 1'b1; mem_ack = 1'b0;
        repeat (4) @(negedge CLK);
        mem_access = 1'b0; #1;
        n_checks++; if ({halted, mem_err} !== 2'b11) begin
            n_fail++; $display("FAIL to_flags got halted %b err %b exp 1/1", halted, mem_err);
        end
        n_checks++; if (wait_cnt !== 4'd4) begin n_fail++; $display("FAIL to_wait_cnt got %0d exp 4", wait_cnt); end
        n_checks++; if ({en_v, clr_v} !== 9'b00000_0000) begin
            n_fail++; $display("FAIL to_halt_out got %b/%b exp 00000/0000", en_v, clr_v);
        end
        repeat (3) @(negedge CLK);
        #1;
        n_checks++; if ({halted, mem_err} !== 2'b11) begin
            n_fail++; $display("FAIL to_sticky got halted %b err %b exp 1/1", halted, mem_err);
        end
        do_reset(); #1;
        n_checks++; if ({halted, mem_err} !== 2'b00) begin
            n_fail++; $display("FAIL to_reset got halted %b err %b exp 0/0", halted, mem_err);
        end
    endtask

    task automatic test_halt_drain();
        do_reset();
        halt_req = 1'b1; #1;
        n_checks++; if ({en_v, clr_v} !== 9'b11111_0000) begin
            n_fail++; $display("FAIL hd_req got %b/%b exp 11111/0000", en_v, clr_v);
        end
        @(negedge CLK); halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if ({en_v, clr_v, halted} !== 10'b01111_1000_0) begin
                n_fail++; $display("FAIL hd_drain%0d got %b/%b h%b exp 01111/1000 h0", i, en_v, clr_v, halted);
            end
            @(negedge CLK);
        end
        #1;
        n_checks++; if ({halted, en_v} !== 6'b1_00000) begin
            n_fail++; $display("FAIL hd_halted got h%b en %b exp h1 00000", halted, en_v);
        end
        @(negedge CLK); #1;
        n_checks++; if ({halted, en_v} !== 6'b0_11111) begin
            n_fail++; $display("FAIL hd_release got h%b en %b exp h0 11111", halted, en_v);
        end
    endtask

    task automatic test_drain_wait();
        do_reset();
        halt_req = 1'b1;
        @(negedge CLK); halt_req = 1'b0;    // DRAIN, count 0 -> 1
        @(negedge CLK);
        mem_access = 1'b1; #1;
        n_checks++; if ({en_v, clr_v} !== 9'b00000_0001) begin
            n_fail++; $display("FAIL dw_freeze got %b/%b exp 00000/0001", en_v, clr_v);
        end
        @(negedge CLK); mem_ack = 1'b1; #1;
        n_checks++; if ({en_v, clr_v} !== 9'b11111_0000) begin
            n_fail++; $display("FAIL dw_ack got %b/%b exp 11111/0000", en_v, clr_v);
        end
        @(negedge CLK); idle();
        repeat (2) @(negedge CLK);
        #1;
        n_checks++; if ({halted, clr_v} !== 5'b0_1000) begin
            n_fail++; $display("FAIL dw_paused got h%b clr %b exp h0 1000", halted, clr_v);
        end
        @(negedge CLK); #1;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL dw_halted got %b exp 1", halted); end
    endtask

    task automatic test_async_reset();
        do_reset();
        halt_req = 1'b1;
        @(negedge CLK); halt_req = 1'b0;
        @(negedge CLK);
        #2 RESET_N = 1'b0; #1;
        n_checks++; if ({en_v, clr_v, halted} !== 10'b11111_0000_0) begin
            n_fail++; $display("FAIL async_rst got %b/%b h%b exp 11111/0000 h0", en_v, clr_v, halted);
        end
        @(negedge CLK); RESET_N = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
        repeat (20) @(negedge CLK);
        idle(); #1;
        n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall got %0d exp 15", stall_cnt); end
    endtask

    initial begin
        RESET_N = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_halt_drain();
        test_drain_wait();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
